// File: rtl/vx_fetch_warp_sched.sv
// Per-core warp fetch scheduler: round-robin selection of ready warps into a registered
// valid/ready request slot, with at most one fetch in flight per warp.
module vx_fetch_warp_sched #(
    parameter int                 NUM_WARPS   = 4,
    parameter int                 NUM_THREADS = 4,
    parameter int                 PC_BITS     = 30,
    parameter int                 UUID_WIDTH  = 16,
    parameter logic [PC_BITS-1:0] STARTUP_PC  = 30'h20000000,
    parameter int                 NW_WIDTH    = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spawn_valid,
    input  logic [NW_WIDTH-1:0]    spawn_wid,
    input  logic [PC_BITS-1:0]     spawn_PC,
    input  logic [NUM_THREADS-1:0] spawn_tmask,
    input  logic                   unlock_valid,
    input  logic [NW_WIDTH-1:0]    unlock_wid,
    input  logic                   br_valid,
    input  logic [NW_WIDTH-1:0]    br_wid,
    input  logic                   br_taken,
    input  logic [PC_BITS-1:0]     br_dest,
    input  logic                   tmc_valid,
    input  logic [NW_WIDTH-1:0]    tmc_wid,
    input  logic [NUM_THREADS-1:0] tmc_tmask,
    output logic                   sched_valid,
    output logic [NW_WIDTH-1:0]    sched_wid,
    output logic [PC_BITS-1:0]     sched_PC,
    output logic [NUM_THREADS-1:0] sched_tmask,
    output logic [UUID_WIDTH-1:0]  sched_uuid,
    input  logic                   sched_ready,
    output logic                   busy
);

    logic [NUM_WARPS-1:0]   active;
    logic [NUM_WARPS-1:0]   stalled;
    logic [PC_BITS-1:0]     pc    [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask [NUM_WARPS];
    logic [NW_WIDTH-1:0]    rr_ptr;
    logic [UUID_WIDTH-1:0]  uuid_cnt;

    logic [NUM_WARPS-1:0]   ready_set;
    logic                   sel_found;
    logic [NW_WIDTH-1:0]    sel_wid;
    logic [NW_WIDTH-1:0]    idx;
    logic                   fire;
    logic                   load;

    assign fire = sched_valid && sched_ready;
    assign load = !sched_valid || fire;

    // First ready warp at or after the round-robin pointer, wrapping.
    always_comb begin
        ready_set = active & ~stalled;
        sel_found = 1'b0;
        sel_wid   = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            idx = rr_ptr + NW_WIDTH'(i);
            if (!sel_found && ready_set[idx]) begin
                sel_found = 1'b1;
                sel_wid   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                active[w]  <= (w == 0);
                stalled[w] <= 1'b0;
                pc[w]      <= (w == 0) ? STARTUP_PC : '0;
                tmask[w]   <= (w == 0) ? '1 : '0;
            end
            sched_valid <= 1'b0;
            sched_wid   <= '0;
            sched_PC    <= '0;
            sched_tmask <= '0;
            sched_uuid  <= '0;
            rr_ptr      <= '0;
            uuid_cnt    <= '0;
            busy        <= 1'b1;
        end else begin
            busy <= |active;

            if (fire) begin
                uuid_cnt      <= uuid_cnt + 1'b1;
                pc[sched_wid] <= sched_PC + 1'b1;
            end

            // A same-cycle fire has already consumed uuid_cnt, so the new request takes the next one.
            if (load) begin
                sched_valid <= sel_found;
                if (sel_found) begin
                    sched_wid   <= sel_wid;
                    sched_PC    <= pc[sel_wid];
                    sched_tmask <= tmask[sel_wid];
                    sched_uuid  <= uuid_cnt + UUID_WIDTH'(fire);
                    rr_ptr      <= sel_wid + NW_WIDTH'(1);
                end
            end

            // Later statements win: spawn > tmc > br > unlock, and br PC over fire PC+1.
            if (unlock_valid)
                stalled[unlock_wid] <= 1'b0;
            if (br_valid) begin
                stalled[br_wid] <= 1'b0;
                if (br_taken)
                    pc[br_wid] <= br_dest;
            end
            if (tmc_valid) begin
                stalled[tmc_wid] <= 1'b0;
                tmask[tmc_wid]   <= tmc_tmask;
                if (tmc_tmask == '0)
                    active[tmc_wid] <= 1'b0;
            end
            if (spawn_valid) begin
                active[spawn_wid]  <= 1'b1;
                stalled[spawn_wid] <= 1'b0;
                pc[spawn_wid]      <= spawn_PC;
                tmask[spawn_wid]   <= spawn_tmask;
            end

            if (load && sel_found)
                stalled[sel_wid] <= 1'b1;
        end
    end

    unlock_on_stalled: assert property (@(posedge clk) disable iff (reset)
        unlock_valid |-> stalled[unlock_wid]);
    br_on_stalled: assert property (@(posedge clk) disable iff (reset)
        br_valid |-> stalled[br_wid]);
    tmc_on_stalled: assert property (@(posedge clk) disable iff (reset)
        tmc_valid |-> stalled[tmc_wid]);

endmodule

// File: tb/tb_vx_fetch_warp_sched.sv
// Directed bench for vx_fetch_warp_sched; a second instance with 2-bit uuids checks the wrap.
module tb_vx_fetch_warp_sched;

    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          spawn_valid;
    logic [NW-1:0] spawn_wid;
    logic [29:0]   spawn_PC;
    logic [3:0]    spawn_tmask;
    logic          unlock_valid;
    logic [NW-1:0] unlock_wid;
    logic          br_valid;
    logic [NW-1:0] br_wid;
    logic          br_taken;
    logic [29:0]   br_dest;
    logic          tmc_valid;
    logic [NW-1:0] tmc_wid;
    logic [3:0]    tmc_tmask;
    logic          sched_ready;

    logic          sched_valid, busy;
    logic [NW-1:0] sched_wid;
    logic [29:0]   sched_PC;
    logic [3:0]    sched_tmask;
    logic [15:0]   sched_uuid;

    logic          s_valid, s_busy;
    logic [NW-1:0] s_wid;
    logic [29:0]   s_PC;
    logic [3:0]    s_tmask;
    logic [1:0]    s_uuid;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    vx_fetch_warp_sched dut (
        .clk(clk), .reset(reset),
        .spawn_valid(spawn_valid), .spawn_wid(spawn_wid), .spawn_PC(spawn_PC), .spawn_tmask(spawn_tmask),
        .unlock_valid(unlock_valid), .unlock_wid(unlock_wid),
        .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest),
        .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_tmask(tmc_tmask),
        .sched_valid(sched_valid), .sched_wid(sched_wid), .sched_PC(sched_PC),
        .sched_tmask(sched_tmask), .sched_uuid(sched_uuid), .sched_ready(sched_ready),
        .busy(busy)
    );

    vx_fetch_warp_sched #(.UUID_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset),
        .spawn_valid(spawn_valid), .spawn_wid(spawn_wid), .spawn_PC(spawn_PC), .spawn_tmask(spawn_tmask),
        .unlock_valid(unlock_valid), .unlock_wid(unlock_wid),
        .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest),
        .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_tmask(tmc_tmask),
        .sched_valid(s_valid), .sched_wid(s_wid), .sched_PC(s_PC),
        .sched_tmask(s_tmask), .sched_uuid(s_uuid), .sched_ready(sched_ready),
        .busy(s_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_req(input string tag, input logic [NW-1:0] wid, input logic [29:0] pc,
                             input logic [3:0] tm, input logic [15:0] uuid);
        check({tag, ".valid"}, 64'(sched_valid), 64'd1);
        check({tag, ".wid"},   64'(sched_wid),   64'(wid));
        check({tag, ".pc"},    64'(sched_PC),    64'(pc));
        check({tag, ".tmask"}, 64'(sched_tmask), 64'(tm));
        check({tag, ".uuid"},  64'(sched_uuid),  64'(uuid));
    endtask

    logic [29:0] base [4];
    logic        fired;
    logic [NW-1:0] fw;

    initial begin
        base[0] = 30'h20000000; base[1] = 30'h100; base[2] = 30'h200; base[3] = 30'h300;
        reset = 1'b1; sched_ready = 1'b0;
        spawn_valid = 1'b0; spawn_wid = '0; spawn_PC = '0; spawn_tmask = '0;
        unlock_valid = 1'b0; unlock_wid = '0;
        br_valid = 1'b0; br_wid = '0; br_taken = 1'b0; br_dest = '0;
        tmc_valid = 1'b0; tmc_wid = '0; tmc_tmask = '0;

        // Reset state, then first request one cycle later
        step(); step();
        reset = 1'b0;
        check("rst.valid", 64'(sched_valid), 64'd0);
        check("rst.busy",  64'(busy), 64'd1);
        check("rst.uuid",  64'(sched_uuid), 64'd0);
        step();
        check_req("first", 2'd0, 30'h20000000, 4'hf, 16'd0);

        // Backpressure with warp 1 ready behind the held warp 0
        spawn_valid = 1'b1; spawn_wid = 2'd1; spawn_PC = 30'h100; spawn_tmask = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            step();
            spawn_valid = 1'b0;
            check_req("hold", 2'd0, 30'h20000000, 4'hf, 16'd0);
        end
        sched_ready = 1'b1;
        step();
        check_req("after_hold", 2'd1, 30'h100, 4'b0011, 16'd1);
        step();
        check("no_unlock.valid", 64'(sched_valid), 64'd0);

        // Taken branch on warp 0 redirects its next fetch
        br_valid = 1'b1; br_wid = 2'd0; br_taken = 1'b1; br_dest = 30'h40;
        step();
        br_valid = 1'b0; br_taken = 1'b0;
        check("br_gap.valid", 64'(sched_valid), 64'd0);
        step();
        check_req("br_taken", 2'd0, 30'h40, 4'hf, 16'd2);
        // Not-taken branch on warp 1 continues sequentially
        br_valid = 1'b1; br_wid = 2'd1; br_taken = 1'b0; br_dest = 30'h3ff;
        step();
        br_valid = 1'b0;
        check("nt_gap.valid", 64'(sched_valid), 64'd0);
        step();
        check_req("br_not_taken", 2'd1, 30'h101, 4'b0011, 16'd3);

        // Reset while a request is held
        sched_ready = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid.valid", 64'(sched_valid), 64'd0);

        // Round robin over 4 warps with unlock one cycle after each fire
        for (int w = 1; w < 4; w++) begin
            spawn_valid = 1'b1; spawn_wid = NW'(w); spawn_PC = base[w]; spawn_tmask = 4'hf;
            step();
        end
        spawn_valid = 1'b0;
        sched_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check_req($sformatf("rr%0d", k), NW'(k % 4), base[k % 4] + 30'(k / 4), 4'hf, 16'(k));
            if (k < 5)
                check($sformatf("uuid2_%0d", k), 64'(s_uuid), 64'(k % 4));
            fired = sched_valid && sched_ready;
            fw = sched_wid;
            step();
            unlock_valid = fired; unlock_wid = fw;
        end
        unlock_valid = 1'b0;

        // Terminating the only active warp
        sched_ready = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; sched_ready = 1'b1;
        check("rst_mid2.valid", 64'(sched_valid), 64'd0);
        step();
        check_req("solo", 2'd0, 30'h20000000, 4'hf, 16'd0);
        step();
        check("solo_fired.valid", 64'(sched_valid), 64'd0);
        tmc_valid = 1'b1; tmc_wid = 2'd0; tmc_tmask = 4'h0;
        step();
        tmc_valid = 1'b0;
        check("tmc0.busy_lag", 64'(busy), 64'd1);
        check("tmc0.valid", 64'(sched_valid), 64'd0);
        step();
        check("tmc0.busy", 64'(busy), 64'd0);
        step(); step();
        check("tmc0.no_reissue", 64'(sched_valid), 64'd0);
        check("tmc0.busy_stays", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vx_fetch_warp_sched.md
Name: vx_fetch_warp_sched

Overview:
- Per-core warp fetch scheduler; it drives the fetch stage's schedule request channel (valid/ready; payload wid, PC, tmask, uuid).
- Holds per-warp PC, thread mask, active and stall state.
- Picks one ready warp per cycle using round-robin.
- Keeps at most one fetch in flight per warp until decode or branch resolution releases it.

Parameters:
- NUM_WARPS, 4, number of warps (power of 2, ≥2); NW_WIDTH = log2(NUM_WARPS).
- NUM_THREADS, 4, threads per warp.
- PC_BITS, 30, PC width in 4-byte word units.
- UUID_WIDTH, 16, instruction trace id width.
- STARTUP_PC, 30'h20000000, warp 0 PC at reset (word units).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- spawn_valid  in  1  activate a warp
- spawn_wid  in  NW_WIDTH  warp to activate
- spawn_PC  in  PC_BITS  start PC
- spawn_tmask  in  NUM_THREADS  start thread mask
- unlock_valid  in  1  decode: fetched instr is not control-flow; release warp
- unlock_wid  in  NW_WIDTH  warp to release
- br_valid  in  1  branch resolved; release warp
- br_wid  in  NW_WIDTH  branch warp
- br_taken  in  1  branch taken
- br_dest  in  PC_BITS  taken target
- tmc_valid  in  1  thread-mask change; release warp
- tmc_wid  in  NW_WIDTH  target warp
- tmc_tmask  in  NUM_THREADS  new mask; zero terminates warp
- sched_valid  out  1  fetch request valid
- sched_wid  out  NW_WIDTH  request warp
- sched_PC  out  PC_BITS  request PC
- sched_tmask  out  NUM_THREADS  request mask
- sched_uuid  out  UUID_WIDTH  request uuid
- sched_ready  in  1  fetch accepts request
- busy  out  1  any warp active

Behaviour:
- Per-warp state: active, stalled, PC, tmask.
- Reset:
  - warp 0: active=1, stalled=0, PC=STARTUP_PC, tmask=all ones.
  - other warps: active=0, stalled=0, PC=0, tmask=0.
  - sched_valid=0, sched_wid/PC/tmask/uuid=0; round-robin pointer=0; uuid counter=0; busy=1 from the first cycle after reset.
  - Reset asserted mid-operation drops any held request and all in-flight state in that same edge.
- Ready set = active & ~stalled.
- Selection:
  - Happens when the output register is empty, or is firing this cycle (sched_valid && sched_ready).
  - Search starts at the round-robin pointer and wraps modulo NUM_WARPS.
  - The selected warp loads into the output register the next cycle and is marked stalled at that same edge, so it cannot be reselected.
  - Pointer becomes selected wid + 1 (wrap).
  - Empty ready set: sched_valid=0 next cycle.
- Output register:
  - sched_* fields stay stable while sched_valid && !sched_ready.
  - Back-to-back issue is allowed: a fire and a new selection in the same cycle give one request per cycle.
  - Latency is 1 cycle from a warp becoming ready to sched_valid, when the output register is idle.
- On fire:
  - PC[sched_wid] <= sched_PC + 1.
  - uuid counter increments and wraps at 2^UUID_WIDTH.
  - sched_uuid shows the counter value at selection time.
- Release events, each applied at the next edge:
  - unlock: stalled=0.
  - br: stalled=0; if br_taken, PC <= br_dest.
  - tmc: stalled=0; tmask <= tmc_tmask; if tmc_tmask==0, active=0.
  - spawn: active=1, stalled=0, PC=spawn_PC, tmask=spawn_tmask.
- Same cycle, same wid: br PC write overrides the fire PC+1 update.
  - Cannot happen on a legal trace; precedence still applies.
- Same cycle, same wid, several release/spawn events: precedence is spawn > tmc > br > unlock.
  - Each field takes the value from the highest-precedence event that writes it.
  - Different wids update independently.
- A release aimed at a non-stalled warp is an error: simulation assertion; the update is still applied.
- Spawn aimed at an active warp: overwrites its state; an in-flight request is not cancelled.
- busy = |active. It is a registered view of active, 1 cycle after the state change.

Test Plan:
- Reset release:
  - Cycle 1: sched_valid=1, wid=0, PC=0x20000000, tmask=4'b1111, uuid=0.
  - After fire with no unlock: sched_valid=0 on following cycles.
- Spawn warps 1, 2, 3 (PC 0x100/0x200/0x300), sched_ready=1, unlock each warp 1 cycle after it fires:
  - Issue order 0,1,2,3,0,1,...; one request per cycle in steady state.
  - uuid goes 0,1,2,... and PC increments by 1 per warp visit.
- Backpressure: sched_ready=0 for 5 cycles with warp 0 held -> all sched_* constant; warp 1 (ready) is not issued until that fire.
- Branch: warp 0 fires at PC 0x20000000, br_valid taken br_dest=0x40 -> next warp 0 request has PC=0x40.
  - Not-taken case -> next request has PC=0x20000001.
- tmc_tmask=0 on warp 0 as the only active warp -> never reissued; busy=0 one cycle later.
- uuid wrap (UUID_WIDTH=2): 5 fires -> uuids 0,1,2,3,0.
  - Reset asserted while sched_valid=1 -> sched_valid=0 the next cycle.
